// File: rtl/wind_pkg.sv
// wind_pkg: shared state encoding, limits and result format for the wind measurement blocks.
package wind_pkg;
  localparam int MEANLEN_MIN = 6;
  localparam int MEANLEN_MAX = 11;
  localparam int RES_W = 16;
  localparam int RES_FRAC = 10;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_TX     = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_ACQ    = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  typedef logic signed [RES_W-1:0] res_t;
  function automatic logic [3:0] clamp_meanlen(input logic [3:0] v);
    return v < 4'(MEANLEN_MIN) ? 4'(MEANLEN_MIN) : v > 4'(MEANLEN_MAX) ? 4'(MEANLEN_MAX) : v;
  endfunction
endpackage

// File: rtl/wind_strobe_gen.sv
// wind_strobe_gen: free-running sample-period divider producing a one-clock endata strobe.
module wind_strobe_gen #(
  parameter int CLKDIV = 20,
  parameter int SAMPLE_PHASE = 18
) (
  input  logic clock,
  input  logic reset,
  output logic endata
);
  localparam int CW = $clog2(CLKDIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic endata_q, endata_d;
  always_comb begin
    cnt_d = (cnt_q == CW'(CLKDIV - 1)) ? '0 : cnt_q + CW'(1);
    endata_d = cnt_d == CW'(SAMPLE_PHASE);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      endata_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      endata_q <= endata_d;
    end
  end
  assign endata = endata_q;
endmodule

// File: rtl/wind_meas_seq.sv
// wind_meas_seq: measurement sequencer (clear, burst, settle, acquire, wait) with a valid/ready result register.
module wind_meas_seq
  import wind_pkg::*;
#(
  parameter int CLKDIV = 20,
  parameter int SAMPLE_PHASE = 18,
  parameter int TXLEN = 8,
  parameter int SETTLE = 64,
  parameter int TIMEOUT = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  input  logic [3:0]       spdmeanlen_in,
  input  logic             speeden,
  input  logic [RES_W-1:0] speedX_in,
  input  logic [RES_W-1:0] speedY_in,
  output logic             endata,
  output logic             dp_clr,
  output logic             txen,
  output logic [3:0]       spdmeanlen,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] speedX,
  output logic [RES_W-1:0] speedY,
  output logic             overrun,
  output logic             timeout,
  output logic             cfg_err
);
  logic [2:0] state_q, state_d;
  logic [11:0] cnt_q, cnt_d, lim;
  logic [3:0] len_q, len_d, clamped;
  logic [RES_W-1:0] x_q, x_d, y_q, y_d;
  logic valid_q, valid_d, ovr_q, ovr_d, to_q, to_d, cfg_q, cfg_d;
  logic hit, cap;
  wind_strobe_gen #(.CLKDIV(CLKDIV), .SAMPLE_PHASE(SAMPLE_PHASE)) u_strobe (
    .clock  (clock),
    .reset  (reset),
    .endata (endata)
  );
  always_comb begin
    clamped = clamp_meanlen(spdmeanlen_in);
    lim = state_q == S_TX ? 12'(TXLEN - 1) :
          state_q == S_SETTLE ? 12'(SETTLE - 1) :
          state_q == S_ACQ ? (12'd1 << len_q) - 12'd1 : 12'(TIMEOUT - 1);
    hit = endata && cnt_q == lim;
    cap = state_q == S_WAIT && speeden && !abort && (!valid_q || out_ready);
    state_d = state_q;
    cnt_d = hit ? '0 : endata ? cnt_q + 12'd1 : cnt_q;
    len_d = len_q;
    ovr_d = ovr_q;
    to_d = to_q;
    cfg_d = cfg_q;
    valid_d = cap | (valid_q & ~out_ready);
    x_d = cap ? speedX_in : x_q;
    y_d = cap ? speedY_in : y_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (start) begin
            state_d = S_CLEAR;
            len_d = clamped;
            cfg_d = clamped != spdmeanlen_in;
            ovr_d = 1'b0;
            to_d = 1'b0;
          end
        end
        // two-clock clear: cnt_q[0] marks the second clock
        S_CLEAR: begin
          cnt_d = cnt_q[0] ? 12'd0 : 12'd1;
          state_d = cnt_q[0] ? S_TX : S_CLEAR;
        end
        S_TX:     state_d = hit ? S_SETTLE : S_TX;
        S_SETTLE: state_d = hit ? S_ACQ : S_SETTLE;
        S_ACQ:    state_d = hit ? S_WAIT : S_ACQ;
        S_WAIT: begin
          if (speeden) begin
            state_d = S_DONE;
            cnt_d = '0;
            ovr_d = ovr_q | ~cap;
          end else if (hit) begin
            state_d = S_DONE;
            to_d = 1'b1;
          end
        end
        S_DONE: begin
          cnt_d = '0;
          state_d = continuous ? S_CLEAR : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      len_q <= 4'(MEANLEN_MIN);
      valid_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      ovr_q <= 1'b0;
      to_q <= 1'b0;
      cfg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      valid_q <= valid_d;
      x_q <= x_d;
      y_q <= y_d;
      ovr_q <= ovr_d;
      to_q <= to_d;
      cfg_q <= cfg_d;
    end
  end
  assign dp_clr = state_q == S_CLEAR;
  assign txen = state_q == S_TX;
  assign busy = state_q != S_IDLE;
  assign spdmeanlen = len_q;
  assign out_valid = valid_q;
  assign speedX = x_q;
  assign speedY = y_q;
  assign overrun = ovr_q;
  assign timeout = to_q;
  assign cfg_err = cfg_q;
endmodule

// File: tb/tb_wind_meas_seq.sv
// tb_wind_meas_seq: clamp vector table, phase-length measurements against a sample-count model, and corner sequences.
module tb_wind_meas_seq;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, continuous = 1'b0;
  logic speeden = 1'b0, out_ready = 1'b0;
  logic [3:0] spdmeanlen_in = 4'd6;
  logic [15:0] speedX_in = '0, speedY_in = '0;
  logic endata, dp_clr, txen, busy, out_valid, overrun, timeout, cfg_err;
  logic [3:0] spdmeanlen;
  logic [15:0] speedX, speedY;
  int n_cmp = 0, n_err = 0;
  logic m_valid = 1'b0, m_ovr = 1'b0, m_to = 1'b0, m_cfg = 1'b0;
  logic [15:0] m_x = '0, m_y = '0;
  int m_len = 6;
  typedef struct { logic [3:0] in; int len; int cfg; } vec_t;
  vec_t tbl [0:6];

  always #5 clock = ~clock;

  wind_meas_seq dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .continuous(continuous),
    .spdmeanlen_in(spdmeanlen_in), .speeden(speeden), .speedX_in(speedX_in), .speedY_in(speedY_in),
    .endata(endata), .dp_clr(dp_clr), .txen(txen), .spdmeanlen(spdmeanlen), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .speedX(speedX), .speedY(speedY),
    .overrun(overrun), .timeout(timeout), .cfg_err(cfg_err)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampm(input int v);
    return v < 6 ? 6 : (v > 11 ? 11 : v);
  endfunction

  // One measurement, timed purely by counting endata pulses in each observable phase.
  task automatic meas(input bit do_start, input int mlin, input bit give, input int wait_s,
                      input logic [15:0] x, input logic [15:0] y, input bit rdy, input bit stale);
    int k, p, target;
    out_ready = rdy;
    if (rdy) m_valid = 1'b0;
    if (do_start) begin
      spdmeanlen_in = 4'(mlin);
      start = 1'b1;
      tick();
      start = 1'b0;
      m_len = clampm(mlin);
      m_cfg = m_len != mlin;
      m_ovr = 1'b0;
      m_to = 1'b0;
      chk("spdmeanlen", int'(spdmeanlen), m_len);
      chk("cfg_err", int'(cfg_err), int'(m_cfg));
      chk("overrun_cleared", int'(overrun), 0);
      chk("timeout_cleared", int'(timeout), 0);
    end
    k = 0;
    while (dp_clr && k < 10) begin k++; tick(); end
    chk("dp_clr_clocks", k, 2);
    chk("txen_first_clock", int'(txen), 1);
    p = 0; k = 0;
    while (txen && k < 1000) begin if (endata) p++; k++; tick(); end
    chk("tx_samples", p, 8);
    target = 64 + (1 << m_len);
    p = 0; k = 0;
    while (p < target && k < 50000) begin
      if (endata) p++;
      speeden = stale && ($urandom_range(0, 7) == 0);
      k++;
      tick();
    end
    speeden = 1'b0;
    chk("busy_through_acq", int'(busy), 1);
    if (give) begin
      p = 0; k = 0;
      while (p < wait_s && k < 2000) begin if (endata) p++; k++; tick(); end
      speedX_in = x;
      speedY_in = y;
      speeden = 1'b1;
      tick();
      speeden = 1'b0;
      if (rdy || !m_valid) begin m_x = x; m_y = y; m_valid = 1'b1; end
      else m_ovr = 1'b1;
      chk("out_valid_capture", int'(out_valid), 1);
      chk("speedX", int'(speedX), int'(m_x));
      chk("speedY", int'(speedY), int'(m_y));
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("busy_done", int'(busy), 1);
      tick();
      if (rdy) m_valid = 1'b0;
      chk("busy_after_done", int'(busy), int'(continuous));
      chk("out_valid_after", int'(out_valid), int'(m_valid));
    end else begin
      p = 0; k = 0;
      while (busy && k < 10000) begin if (endata) p++; k++; tick(); end
      m_to = 1'b1;
      if (rdy) m_valid = 1'b0;
      chk("wait_samples", p, 256);
      chk("timeout", int'(timeout), 1);
      chk("out_valid_no_capture", int'(out_valid), int'(m_valid));
      chk("speedX_held", int'(speedX), int'(m_x));
    end
    chk("timeout_flag", int'(timeout), int'(m_to));
  endtask

  initial begin
    int first, second, pulses, k;
    logic [15:0] rx, ry;
    tbl[0] = '{4'd3, 6, 1};
    tbl[1] = '{4'd14, 11, 1};
    tbl[2] = '{4'd6, 6, 0};
    tbl[3] = '{4'd11, 11, 0};
    tbl[4] = '{4'd0, 6, 1};
    tbl[5] = '{4'd15, 11, 1};
    tbl[6] = '{4'd9, 9, 0};
    tick(); tick();
    chk("rst_endata", int'(endata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_txen_dpclr", int'({txen, dp_clr}), 0);
    chk("rst_spdmeanlen", int'(spdmeanlen), 6);
    chk("rst_result", int'({out_valid, speedX, speedY}), 0);
    chk("rst_flags", int'({overrun, timeout, cfg_err}), 0);
    reset = 1'b1;
    // release at a negedge: the Nth negedge afterwards follows the Nth rising edge
    first = -1; second = -1; pulses = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (endata) begin
        pulses++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
    end
    chk("endata_first", first, 18);
    chk("endata_period", second - first, 20);
    chk("endata_pulses_in_60", pulses, 3);
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      spdmeanlen_in = tbl[i].in;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("tbl_spdmeanlen", int'(spdmeanlen), tbl[i].len);
      chk("tbl_cfg_err", int'(cfg_err), tbl[i].cfg);
      chk("tbl_dp_clr", int'(dp_clr), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("tbl_abort_busy", int'(busy), 0);
    end
    meas(1'b1, 6, 1'b1, 3, 16'h0400, 16'hFC00, 1'b1, 1'b1);
    meas(1'b1, 14, 1'b0, 0, 16'h0, 16'h0, 1'b1, 1'b1);
    continuous = 1'b1;
    meas(1'b1, 6, 1'b1, 2, 16'h1234, 16'h5678, 1'b0, 1'b0);
    meas(1'b0, 6, 1'b1, 1, 16'h9ABC, 16'hDEF0, 1'b0, 1'b0);
    continuous = 1'b0;
    out_ready = 1'b1;
    chk("ovr_valid_held", int'(out_valid), 1);
    tick();
    m_valid = 1'b0;
    chk("ovr_valid_drop", int'(out_valid), 0);
    k = 0;
    while (!txen && k < 100) begin k++; tick(); end
    repeat (30) tick();
    chk("abort_pre_txen", int'(txen), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_txen", int'(txen), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_dp_clr", int'(dp_clr), 0);
    chk("abort_keeps_overrun", int'(overrun), 1);
    chk("abort_keeps_speedX", int'(speedX), 16'h1234);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", int'(busy), 0);
    for (int r = 0; r < 4; r++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      meas(1'b1, int'($urandom_range(0, 7)), 1'b1, int'($urandom_range(0, 5)), rx, ry,
           1'($urandom_range(0, 1)), 1'b1);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!txen && k < 100) begin k++; tick(); end
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    chk("async_reset_txen", int'(txen), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_valid", int'(out_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
